// File: rtl/fifo_sync_ctl.sv
// Single-clock FIFO controller with exact occupancy, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_sync_ctl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rd_acc_s, wr_acc_s;
    logic [DATA_WIDTH-1:0] head_s;

    // Accept decisions, next occupancy, next flags and next read-port contents.
    always_comb begin
        rd_acc_s = rd_en && !empty_q;
        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        wr_acc_s = wr_en && (!full_q || rd_acc_s);

        wr_ptr_d = wr_acc_s ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
        rd_ptr_d = rd_acc_s ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        full_d         = (count_d == CW'(DEPTH));
        empty_d        = (count_d == CW'(1'b0));
        almost_full_d  = (count_d >= CW'(AF_THRESH));
        almost_empty_d = (count_d <= CW'(AE_THRESH));

        overflow_d  = (overflow_q  && !clr_err) || (wr_en && full_q && !rd_acc_s);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty_q);

        // The next head is the incoming word when it lands in the slot the read pointer moves to.
        head_s = (wr_acc_s && (rd_ptr_d == wr_ptr_q)) ? data_in : mem_q[rd_ptr_d];

        if (FWFT != 0) begin
            data_d     = empty_d ? data_q : head_s;
            rd_valid_d = !empty_d;
        end else begin
            data_d     = rd_acc_s ? mem_q[rd_ptr_q] : data_q;
            rd_valid_d = rd_acc_s;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Pointers, occupancy, status flags and the read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
            data_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            rd_valid_q     <= rd_valid_d;
            data_q         <= data_d;
        end
    end

    assign data_out     = data_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctl.sv
// Bench for fifo_sync_ctl: a standard-mode and an FWFT-mode instance share stimulus
// and are checked against a queue-based reference model.
module tb_fifo_sync_ctl;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] a_data_out, b_data_out;
    logic       a_rd_valid, b_rd_valid, a_full, b_full, a_empty, b_empty;
    logic       a_af, b_af, a_ae, b_ae, a_ov, b_ov, a_uf, b_uf;
    logic [4:0] a_count, b_count;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mq[$];
    bit         m_ov, m_uf, m_rv0;
    logic [7:0] m_d0;

    fifo_sync_ctl #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(a_data_out), .rd_valid(a_rd_valid), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ov), .underflow(a_uf));

    fifo_sync_ctl #(.DATA_WIDTH(8), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(b_data_out), .rd_valid(b_rd_valid), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ov), .underflow(b_uf));

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_ov = 1'b0; m_uf = 1'b0; m_rv0 = 1'b0; m_d0 = 8'h00;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, land 1 time unit later.
    task automatic step(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
        bit racc, wacc;
        int sz;
        wr_en = wr; data_in = din; rd_en = rd; clr_err = clr;
        sz   = mq.size();
        racc = rd && (sz > 0);
        wacc = wr && ((sz < D) || racc);
        @(posedge clk);
        m_ov  = (m_ov && !clr) || (wr && (sz == D) && !racc);
        m_uf  = (m_uf && !clr) || (rd && (sz == 0));
        m_rv0 = racc;
        if (racc) m_d0 = mq.pop_front();
        if (wacc) mq.push_back(din);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        model_clear();
        n_total++; if (a_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", a_count); else n_pass++;
        n_total++; if ({a_empty, a_ae, a_full, a_af} !== 4'b1100) $display("FAIL reset_flags got=%b exp=1100", {a_empty, a_ae, a_full, a_af}); else n_pass++;
        n_total++; if ({a_rd_valid, a_ov, a_uf, b_rd_valid} !== 4'b0000) $display("FAIL reset_valid_err got=%b exp=0000", {a_rd_valid, a_ov, a_uf, b_rd_valid}); else n_pass++;
        n_total++; if (a_data_out !== 8'h00 || b_data_out !== 8'h00) $display("FAIL reset_data got=%h/%h exp=00/00", a_data_out, b_data_out); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            n_total++; if (a_count !== 5'(i + 1)) $display("FAIL fill_count got=%0d exp=%0d", a_count, i + 1); else n_pass++;
            n_total++; if (a_af !== ((i + 1) >= 14)) $display("FAIL fill_almost_full at count %0d got=%b", i + 1, a_af); else n_pass++;
        end
        n_total++; if ({a_full, a_empty} !== 2'b10) $display("FAIL fill_full_empty got=%b exp=10", {a_full, a_empty}); else n_pass++;
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_total++; if (a_ov !== 1'b1) $display("FAIL fill_overflow got=%b exp=1", a_ov); else n_pass++;
        n_total++; if (a_count !== 5'd16) $display("FAIL fill_overflow_count got=%0d exp=16", a_count); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (a_data_out !== 8'(i) || a_rd_valid !== 1'b1) $display("FAIL drain_data got=%h/%b exp=%h/1", a_data_out, a_rd_valid, 8'(i)); else n_pass++;
            n_total++; if (a_ae !== ((15 - i) <= 2)) $display("FAIL drain_almost_empty at count %0d got=%b", 15 - i, a_ae); else n_pass++;
        end
        n_total++; if (a_empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", a_empty); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++; if (a_rd_valid !== 1'b0 || a_data_out !== 8'h0F) $display("FAIL drain_pulse got=%b/%h exp=0/0f", a_rd_valid, a_data_out); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if ({a_ov, a_uf} !== 2'b11) $display("FAIL drain_underflow got=%b exp=11", {a_ov, a_uf}); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if ({a_ov, a_uf} !== 2'b00) $display("FAIL clr_err got=%b exp=00", {a_ov, a_uf}); else n_pass++;
    endtask

    task automatic test_full_rw();
        logic [7:0] exp;
        for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'hA0 + 8'(k), 1'b1, 1'b0);
            n_total++; if (a_count !== 5'd16 || a_ov !== 1'b0 || a_full !== 1'b1) $display("FAIL full_rw_status got=%0d/%b/%b exp=16/0/1", a_count, a_ov, a_full); else n_pass++;
            n_total++; if (a_data_out !== 8'(k)) $display("FAIL full_rw_data got=%h exp=%h", a_data_out, 8'(k)); else n_pass++;
        end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            exp = (i < 12) ? 8'(i + 4) : 8'hA0 + 8'(i - 12);
            n_total++; if (a_data_out !== exp) $display("FAIL wrap_data got=%h exp=%h", a_data_out, exp); else n_pass++;
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_total++; if (a_uf !== 1'b1 || a_count !== 5'd1) $display("FAIL empty_rw got=%b/%0d exp=1/1", a_uf, a_count); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        n_total++; if (a_data_out !== 8'h55 || a_rd_valid !== 1'b1) $display("FAIL empty_rw_read got=%h/%b exp=55/1", a_data_out, a_rd_valid); else n_pass++;
        n_total++; if (a_uf !== 1'b0) $display("FAIL empty_rw_clr got=%b exp=0", a_uf); else n_pass++;
    endtask

    task automatic test_fwft();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        n_total++; if (b_data_out !== 8'h3C || b_rd_valid !== 1'b1) $display("FAIL fwft_show got=%h/%b exp=3c/1", b_data_out, b_rd_valid); else n_pass++;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_total++; if (b_data_out !== 8'h3C || b_count !== 5'd1) $display("FAIL fwft_hold got=%h/%0d exp=3c/1", b_data_out, b_count); else n_pass++;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (b_empty !== 1'b1 || b_rd_valid !== 1'b0 || b_uf !== 1'b0) $display("FAIL fwft_pop got=%b/%b/%b exp=1/0/0", b_empty, b_rd_valid, b_uf); else n_pass++;
    endtask

    task automatic test_random();
        logic [10:0] exp_st;
        int sz, wp;
        for (int c = 0; c < 600; c++) begin
            wp = ((c / 60) % 2 == 0) ? 75 : 25;
            step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 31) == 0);
            sz = mq.size();
            exp_st = {5'(sz), sz == D, sz == 0, sz >= 14, sz <= 2, m_ov, m_uf};
            n_total++; if ({a_count, a_full, a_empty, a_af, a_ae, a_ov, a_uf} !== exp_st) $display("FAIL rnd_std_status cyc=%0d got=%h exp=%h", c, {a_count, a_full, a_empty, a_af, a_ae, a_ov, a_uf}, exp_st); else n_pass++;
            n_total++; if ({b_count, b_full, b_empty, b_af, b_ae, b_ov, b_uf} !== exp_st) $display("FAIL rnd_fwft_status cyc=%0d got=%h exp=%h", c, {b_count, b_full, b_empty, b_af, b_ae, b_ov, b_uf}, exp_st); else n_pass++;
            n_total++; if (a_data_out !== m_d0 || a_rd_valid !== m_rv0) $display("FAIL rnd_std_read cyc=%0d got=%h/%b exp=%h/%b", c, a_data_out, a_rd_valid, m_d0, m_rv0); else n_pass++;
            n_total++; if (b_rd_valid !== (sz > 0)) $display("FAIL rnd_fwft_valid cyc=%0d got=%b exp=%b", c, b_rd_valid, sz > 0); else n_pass++;
            if (sz > 0) begin
                n_total++; if (b_data_out !== mq[0]) $display("FAIL rnd_fwft_data cyc=%0d got=%h exp=%h", c, b_data_out, mq[0]); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        n_total++; if (a_count !== 5'd7 || a_data_out !== 8'h70) $display("FAIL async_pre got=%0d/%h exp=7/70", a_count, a_data_out); else n_pass++;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        model_clear();
        n_total++; if (a_count !== 5'd0 || b_count !== 5'd0) $display("FAIL async_count got=%0d/%0d exp=0/0", a_count, b_count); else n_pass++;
        n_total++; if ({a_empty, a_ae, a_full, a_af, a_rd_valid, b_rd_valid} !== 6'b110000) $display("FAIL async_flags got=%b exp=110000", {a_empty, a_ae, a_full, a_af, a_rd_valid, b_rd_valid}); else n_pass++;
        n_total++; if (a_data_out !== 8'h00 || b_data_out !== 8'h00) $display("FAIL async_data got=%h/%h exp=00/00", a_data_out, b_data_out); else n_pass++;
        #1 reset_n = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b0);
        n_total++; if (a_count !== 5'd1 || b_data_out !== 8'h99) $display("FAIL async_resume got=%0d/%h exp=1/99", a_count, b_data_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
